// File: rtl/ins_decode_stage.sv
// MIPS instruction decode stage: decodes {instruction, pc} at accept time and
// buffers the decoded fields in a small queue so decode can run ahead of execute.
module ins_decode_stage #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [PC_W-1:0]  p_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       ins_type,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [IMM_W-1:0] imm_ext,
  output logic [PC_W-1:0]  br_target,
  output logic [PC_W-1:0]  j_target,
  output logic [PC_W-1:0]  pc_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0]       ins_type;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [IMM_W-1:0] imm_ext;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  j_target;
    logic [PC_W-1:0]  pc;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             dec;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [PC_W-1:0]    pc4;
  logic signed [15:0] imm_s;
  logic [5:0]         op;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign op    = instruction[31:26];
  assign imm_s = instruction[15:0];
  assign pc4   = p_count + PC_W'(4);

  // Fields outside the decoded type stay zero so nothing stale reaches execute.
  always_comb begin
    dec          = '0;
    dec.opcode   = op;
    dec.pc       = p_count;
    if (op == 6'h00) begin
      dec.ins_type = 2'd0;
      dec.rs       = instruction[25:21];
      dec.rt       = instruction[20:16];
      dec.rd       = instruction[15:11];
      dec.shamt    = instruction[10:6];
      dec.funct    = instruction[5:0];
    end else if (op == 6'h02 || op == 6'h03) begin
      dec.ins_type = 2'd2;
      dec.j_target = (pc4 & ~PC_W'(28'hFFF_FFFF)) | PC_W'({instruction[25:0], 2'b00});
      if (op == 6'h03) dec.rd = 5'd31;
    end else begin
      dec.ins_type  = 2'd1;
      dec.rs        = instruction[25:21];
      dec.rt        = instruction[20:16];
      dec.br_target = pc4 + (PC_W'(imm_s) << 2);
      case (op)
        6'h0C, 6'h0D, 6'h0E: dec.imm_ext = IMM_W'(instruction[15:0]);
        6'h0F:               dec.imm_ext = IMM_W'({instruction[15:0], 16'h0000});
        default:             dec.imm_ext = IMM_W'(imm_s);
      endcase
    end
  end

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign ins_type  = head.ins_type;
  assign opcode    = head.opcode;
  assign rs        = head.rs;
  assign rt        = head.rt;
  assign rd        = head.rd;
  assign shamt     = head.shamt;
  assign funct     = head.funct;
  assign imm_ext   = head.imm_ext;
  assign br_target = head.br_target;
  assign j_target  = head.j_target;
  assign pc_out    = head.pc;

endmodule

// File: tb/tb_ins_decode_stage.sv
// Directed bench for ins_decode_stage: literal checks on known encodings plus a
// queue of independently modelled decodes compared whenever an entry is consumed.
module tb_ins_decode_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] p_count;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  ins_type;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext, br_target, j_target, pc_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  t;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] imm, br, jt, pc;
  } exp_t;

  exp_t sb[$];

  ins_decode_stage #(.PC_W(32), .IMM_W(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .p_count(p_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .ins_type(ins_type), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm_ext(imm_ext),
    .br_target(br_target), .j_target(j_target), .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic [31:0] pc4, sx;
    e   = '0;
    e.op = w[31:26];
    e.pc = pc;
    pc4 = pc + 32'd4;
    sx  = {{16{w[15]}}, w[15:0]};
    if (w[31:26] == 6'd0) begin
      e.t = 2'd0; e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11];
      e.sh = w[10:6]; e.fn = w[5:0];
    end else if (w[31:27] == 5'b00001) begin
      e.t  = 2'd2;
      e.jt = {pc4[31:28], w[25:0], 2'b00};
      e.rd = w[26] ? 5'd31 : 5'd0;
    end else begin
      e.t = 2'd1; e.rs = w[25:21]; e.rt = w[20:16];
      if (w[31:26] == 6'h0C || w[31:26] == 6'h0D || w[31:26] == 6'h0E) e.imm = {16'h0, w[15:0]};
      else if (w[31:26] == 6'h0F) e.imm = {w[15:0], 16'h0};
      else e.imm = sx;
      e.br = pc4 + {sx[29:0], 2'b00};
    end
    return e;
  endfunction

  task automatic cmp_head(input exp_t e);
    check("type",  32'(ins_type), 32'(e.t));
    check("opcode", 32'(opcode),  32'(e.op));
    check("rs",    32'(rs),       32'(e.rs));
    check("rt",    32'(rt),       32'(e.rt));
    check("rd",    32'(rd),       32'(e.rd));
    check("shamt", 32'(shamt),    32'(e.sh));
    check("funct", 32'(funct),    32'(e.fn));
    check("imm_ext",   imm_ext,   e.imm);
    check("br_target", br_target, e.br);
    check("j_target",  j_target,  e.jt);
    check("pc_out",    pc_out,    e.pc);
  endtask

  // Inputs are set at posedge+1; handshakes are judged at posedge+2 and the
  // scoreboard mirrors what the edge will do.
  task automatic tick();
    logic fi, fo;
    exp_t e;
    #1;
    fi = in_valid && in_ready && !reset && !flush;
    fo = out_valid && out_ready && !reset && !flush;
    if (fo) begin
      check("pop_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp_head(e);
      end
    end
    if (fi) sb.push_back(model(instruction, p_count));
    if (reset || flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic rst, input logic fl, input logic iv,
                     input logic [31:0] w, input logic [31:0] pc, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; instruction = w; p_count = pc; out_ready = ordy;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_fields"}, 32'({ins_type, opcode, rs, rt, rd, shamt, funct} != 0), 32'd0);
    check({tag, "_imm"},  imm_ext,   32'd0);
    check({tag, "_br"},   br_target, 32'd0);
    check({tag, "_jt"},   j_target,  32'd0);
    check({tag, "_pc"},   pc_out,    32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instruction = '0; p_count = '0; out_ready = 1'b0;
    drv(1, 0, 0, 32'h0, 32'h0, 0);
    drv(1, 0, 0, 32'h0, 32'h0, 0);
    check_all_zero("reset");

    // R-type add $3,$1,$2
    drv(0, 0, 1, 32'h0022_1820, 32'h0000_1000, 0);
    check("r_latency", 32'(out_valid), 32'd1);
    check("r_type", 32'(ins_type), 32'd0);
    check("r_rs", 32'(rs), 32'd1);
    check("r_rt", 32'(rt), 32'd2);
    check("r_rd", 32'(rd), 32'd3);
    check("r_funct", 32'(funct), 32'h20);
    check("r_imm", imm_ext, 32'd0);
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    check("r_drained", 32'(out_valid), 32'd0);

    // Immediate extension, streamed with pop and push in the same cycle
    drv(0, 0, 1, 32'h2008_FFFF, 32'h0000_2000, 1);
    check("addi_imm", imm_ext, 32'hFFFF_FFFF);
    drv(0, 0, 1, 32'h3408_FFFF, 32'h0000_2004, 1);
    check("ori_imm", imm_ext, 32'h0000_FFFF);
    drv(0, 0, 1, 32'h3C08_1234, 32'h0000_2008, 1);
    check("lui_imm", imm_ext, 32'h1234_0000);
    check("lui_type", 32'(ins_type), 32'd1);
    drv(0, 0, 0, 32'h0, 32'h0, 1);

    // Jumps and branches
    drv(0, 0, 1, 32'h0C00_0010, 32'h0040_0000, 0);
    check("jal_type", 32'(ins_type), 32'd2);
    check("jal_target", j_target, 32'h0000_0040);
    check("jal_rd", 32'(rd), 32'd31);
    check("jal_rs", 32'(rs), 32'd0);
    drv(0, 0, 1, 32'h1000_FFFF, 32'h0000_0100, 1);
    check("beq_target", br_target, 32'h0000_0100);
    check("beq_jt", j_target, 32'd0);
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    drv(0, 0, 1, 32'h2400_0001, 32'hFFFF_FFFC, 0);
    check("wrap_br", br_target, 32'h0000_0004);
    drv(0, 0, 0, 32'h0, 32'h0, 1);

    // Backpressure: three words offered into a two-entry queue
    drv(0, 0, 1, 32'h0085_3022, 32'h0000_3000, 0);
    drv(0, 0, 1, 32'h2129_0007, 32'h0000_3004, 0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drv(0, 0, 1, 32'h0800_0100, 32'h0000_3008, 0);
    check("full_hold_pc", pc_out, 32'h0000_3000);
    check("full_still", 32'(in_ready), 32'd0);
    drv(0, 0, 1, 32'h0800_0100, 32'h0000_3008, 1);
    check("full_no_push_on_pop", 32'(in_ready), 32'd1);
    check("bp_head_second", pc_out, 32'h0000_3004);
    drv(0, 0, 1, 32'h0800_0100, 32'h0000_3008, 1);
    check("bp_head_third", pc_out, 32'h0000_3008);
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Concurrent push and pop at count==1
    drv(0, 0, 1, $urandom, {$urandom_range(0, 32'h0FFF_FFFF), 2'b00}, 0);
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 1, $urandom, {$urandom_range(0, 32'h0FFF_FFFF), 2'b00}, 1);
      check("pp_valid", 32'(out_valid), 32'd1);
      check("pp_ready", 32'(in_ready), 32'd1);
    end
    drv(0, 0, 0, 32'h0, 32'h0, 1);
    check("pp_drained", 32'(out_valid), 32'd0);

    // Flush with two queued and a push offered
    drv(0, 0, 1, 32'h0022_1820, 32'h0000_4000, 0);
    drv(0, 0, 1, 32'h2008_0005, 32'h0000_4004, 0);
    drv(0, 1, 1, 32'h3C08_BEEF, 32'h0000_4008, 0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    drv(0, 0, 1, 32'h3408_00AA, 32'h0000_5000, 0);
    check("post_flush_pc", pc_out, 32'h0000_5000);
    drv(0, 0, 0, 32'h0, 32'h0, 1);

    // Same again with reset instead of flush
    drv(0, 0, 1, 32'h0C00_0020, 32'h0000_6000, 0);
    drv(0, 0, 1, 32'h2008_8000, 32'h0000_6004, 0);
    drv(1, 0, 1, 32'h3C08_BEEF, 32'h0000_6008, 1);
    check_all_zero("mid_reset");
    drv(0, 0, 1, 32'h0000_0000, 32'h0000_7000, 0);
    drv(0, 0, 0, 32'h0, 32'h0, 1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
